// File: rtl/bram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_pkg
//   Shared types and constants for the block-RAM stream readers.
//   state_t   : sequencer state (IDLE, READ, DRAIN, DONE)
//   BUF_DEPTH : output buffer depth; this is also the number of words that may
//               be outstanding (buffered + in flight) at any time.
// -----------------------------------------------------------------------------
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// -----------------------------------------------------------------------------
// skid_fifo2
//   Two-entry FIFO that absorbs the one-cycle read latency of a block RAM.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push       : write push_data this cycle
//     push_data  : entry to store
//     pop        : drop the head entry this cycle
//     occ        : number of stored entries (0..2)
//     head       : oldest entry; stable until it is popped
//   A push and a pop in the same cycle leave occ unchanged. A push into a full
//   FIFO is accepted only if a pop frees a slot in the same cycle.
// -----------------------------------------------------------------------------
module skid_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (occ == 2'(BUF_DEPTH));
    do_pop  = pop && (occ != 2'd0);
    do_push = push && (!full || do_pop);
  end

  // NOTE: the two entries are reset so the stream payload reads 0 after reset;
  // larger RAM-style storage would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//   Streams count words starting at base_addr (wrapping modulo DEPTH) out of a
//   single-port block RAM with one-cycle registered read latency onto a
//   valid/ready stream, sustaining one beat per cycle.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     start               : begin a transfer (sampled only in IDLE)
//     base_addr, count    : first word address / number of words (0..DEPTH)
//     busy                : transfer in progress (READ or DRAIN)
//     done                : one-cycle pulse at transfer end
//     ram_en, ram_we      : RAM read strobe, write enable (always 0)
//     ram_addr, ram_dout  : RAM address, RAM read data (valid cycle after en)
//     m_valid, m_ready    : stream handshake
//     m_data, m_last      : beat payload, final-beat marker
// -----------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  last_issue;
  logic                  inflight;       // a read was issued last cycle
  logic                  inflight_last;  // ...and it was the final word
  logic [1:0]            occ;
  logic [WIDTH:0]        head;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit_used;

  // Credit: words that will still be held (buffered or in flight) after this
  // cycle's pop. A new read may only go out if that leaves a free slot, which
  // keeps the 2-entry buffer from ever overflowing under backpressure.
  // NOTE: combinational logic uses blocking assignments with every output
  // given a value on every path, so no latch is inferred.
  always_comb begin
    pop         = m_valid && m_ready;
    credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue       = (credit_used < 3'(BUF_DEPTH));
    ram_en      = (state == READ) && issue;
    last_issue  = (remaining == (ADDR_WIDTH+1)'(1));
    // Explicit wrap so non-power-of-two depths stay in range.
    ptr_next    = (ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= ram_en;
      inflight_last <= ram_en && last_issue;
      case (state)
        IDLE: begin
          if (start) begin
            ptr       <= base_addr;
            remaining <= count;
            state     <= (count == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (ram_en) begin
            ptr       <= ptr_next;
            remaining <= remaining - 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data({ram_dout, inflight_last}),
    .pop      (pop),
    .occ      (occ),
    .head     (head)
  );

  assign ram_we   = 1'b0;
  assign ram_addr = ptr;
  assign busy     = (state == READ) || (state == DRAIN);
  assign done     = (state == DONE);
  assign m_valid  = (occ != 2'd0);
  assign m_data   = head[WIDTH:1];
  assign m_last   = head[0];

endmodule
